tsc_trigger_monitor: RTL and testbench
======================================

# tsc_trigger_monitor

Observer for the trigger line of the cycle-count trigger block. It sits beside the trigger generator and watches its `trigger` output. For every rising edge it records a timestamp from a free-running cycle counter, keeps a saturating activation count, and raises a sticky alarm once a threshold is reached. Timestamps are queued in a small FIFO and drained by a host through a valid/ready handshake.

## Interface
- `TS_WIDTH`, 16: width of the timestamp counter and of `evt_ts`.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `CNT_WIDTH`, 8: width of the activation counter `evt_count`.
- `ALARM_THRESH`, 3: activation count at which `alarm` sets; range 1..2^CNT_WIDTH-1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `trigger`  in  1  monitored trigger line, synchronous to `clk`.
- `clear`  in  1  synchronous clear of count, overflow, alarm and FIFO; `timestamp` keeps running.
- `evt_valid`  out  1  FIFO head is valid.
- `evt_ready`  in  1  host accepts the head.
- `evt_ts`  out  TS_WIDTH  timestamp at the FIFO head.
- `evt_count`  out  CNT_WIDTH  total rising edges seen; saturates at all-ones.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `alarm`  out  1  sticky: `evt_count` has reached `ALARM_THRESH`.

## Operation
- `timestamp` register: increments every cycle and wraps from 2^TS_WIDTH-1 to 0.
- `trig_d` register holds the previous sample of `trigger`.
- Edge detection: `edge = trigger & ~trig_d`.
- `trig_d` resets to 1, so a `trigger` that is high out of reset is not counted.
- On `edge`:
  - push the current `timestamp` value into the FIFO;
  - increment `evt_count`, saturating at 2^CNT_WIDTH-1.
- Pop: occurs when `evt_valid & evt_ready`.
- Push while full:
  - With a simultaneous pop, both the push and the pop occur and no overflow is flagged.
  - Without a pop, the event is dropped and `overflow` sets. `evt_count` still increments.
- `alarm` sets on the cycle `evt_count` becomes ≥ `ALARM_THRESH`. It stays set until reset or `clear`.
- `clear`:
  - empties the FIFO and zeroes `evt_count`, `overflow` and `alarm`;
  - an `edge` in the same cycle is discarded (`clear` wins);
  - `trig_d` still updates.
- `evt_ts` is undefined when `evt_valid` is 0; the bench must not check it then.
- FIFO states: EMPTY, PARTIAL, FULL.
  - Occupancy is tracked with a count register of $clog2(DEPTH)+1 bits.
  - Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - outputs: `evt_valid`=0, `evt_count`=0, `overflow`=0, `alarm`=0;
  - internal: `timestamp`=0, FIFO empty, `trig_d`=1.
- Reset and `clear` take effect at the sampling edge; outputs show the reset value in the following cycle.
- An edge sampled at clock N (`trigger`=1 at N, `trig_d`=0) behaves as follows:
  - `evt_ts` = `timestamp` value held during cycle N;
  - with an empty FIFO, `evt_valid`=1 from cycle N+1 (latency 1);
  - `evt_count` updates at N+1;
  - `alarm` updates at N+1, in the same cycle `evt_count` crosses the threshold.
- Handshake:
  - `evt_valid` and `evt_ts` are registered outputs; no combinational path from `evt_ready`;
  - head is stable until accepted;
  - back-to-back pops are allowed, one per cycle.
- Minimum edge spacing is 2 cycles, so at most one push per cycle.
- Reset mid-operation: queued events are lost and no partial pop completes.

## Structure
- Shared package `tsc_mon_pkg` holds:
  - default values for `TS_WIDTH`, `DEPTH`, `CNT_WIDTH` and `ALARM_THRESH`;
  - `typedef logic [TS_WIDTH-1:0] ts_t`;
  - the FIFO state enum `{EMPTY, PARTIAL, FULL}`.
- One sub-module, `tsc_ts_fifo`: a synchronous DEPTH×TS_WIDTH FIFO.
  - Ports: push, pop, clear, full, empty, head.
  - Same `clk`/`rst` convention as the top.
- Top level contains only edge detection, the timestamp counter, the counters and the sticky flags.

## Test plan
- **Reset:** hold `rst`=0 with `trigger`=1 for 3 cycles, then release with `trigger` held at 1.
  - Required: `evt_valid`=0 and `evt_count`=0 throughout (no spurious edge).
- **Single event:** `trigger` 0→1 when `timestamp`=0x0010, `evt_ready`=1.
  - Required: next cycle `evt_valid`=1, `evt_ts`=0x0010, `evt_count`=1; `evt_valid`=0 one cycle later.
- **Overflow:** `evt_ready`=0; drive 5 edges 2 cycles apart starting at `timestamp`=0x0100.
  - Required: FIFO holds 0x0100, 0x0102, 0x0104, 0x0106; the 5th edge (0x0108) is dropped.
  - Required: `overflow`=1, `evt_count`=5, `alarm`=1 (alarm set after the 3rd edge).
- **Full with simultaneous pop:** FIFO full, `evt_ready`=1, edge in the same cycle.
  - Required: head advances, new timestamp is enqueued, `overflow` stays 0.
- **Wrap and saturation:** run until `timestamp` wraps 0xFFFF→0x0000 and put an edge on 0x0000.
  - Required: `evt_ts`=0x0000.
  - Then force 300 edges: required `evt_count`=255.
- **Clear:** assert `clear` with FIFO non-empty, `alarm`=1, and an edge in the same cycle.
  - Required: next cycle `evt_valid`=0, `evt_count`=0, `alarm`=0, `overflow`=0.

Source files
------------

// File: rtl/tsc_mon_pkg.sv
// Shared definitions for the trigger monitor: default parameter values,
// the timestamp type and the encoding of the timestamp FIFO states.
package tsc_mon_pkg;

  localparam int TS_WIDTH_DEF     = 16;
  localparam int DEPTH_DEF        = 4;
  localparam int CNT_WIDTH_DEF    = 8;
  localparam int ALARM_THRESH_DEF = 3;

  typedef logic [TS_WIDTH_DEF-1:0] ts_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/tsc_ts_fifo.sv
// Synchronous DEPTH x WIDTH timestamp FIFO.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-low reset
//   push, din - enqueue din (accepted when not full, or when full with a pop)
//   pop       - dequeue the head (ignored while empty)
//   clear     - synchronous flush, wins over push/pop
//   full      - DEPTH entries held
//   empty     - no entries held
//   head      - oldest entry; meaningless while empty
//
// state   | meaning
// EMPTY   | count == 0, head invalid
// PARTIAL | 0 < count < DEPTH
// FULL    | count == DEPTH, a push only lands together with a pop
module tsc_ts_fifo
  import tsc_mon_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = TS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  fifo_state_t      state;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    state = PARTIAL;
    if (count == '0)
      state = EMPTY;
    else if (count == (AW+1)'(DEPTH))
      state = FULL;
  end

  assign full  = (state == FULL);
  assign empty = (state == EMPTY);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only exposed through count.
  always_ff @(posedge clk) begin
    if (rst && !clear && do_push)
      mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/tsc_trigger_monitor.sv
// Observer for the cycle-count trigger line. Timestamps each rising edge of
// trigger, queues the timestamps for a host, counts activations (saturating)
// and raises sticky overflow / alarm flags.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-low reset
//   trigger    - monitored line, synchronous to clk
//   clear      - flush FIFO, zero count/overflow/alarm (timestamp keeps running)
//   evt_valid  - FIFO head valid
//   evt_ready  - host accepts the head
//   evt_ts     - timestamp at the FIFO head
//   evt_count  - rising edges seen, saturating at all-ones
//   overflow   - sticky: an edge was dropped on a full FIFO
//   alarm      - sticky: evt_count reached ALARM_THRESH
module tsc_trigger_monitor
  import tsc_mon_pkg::*;
#(
  parameter int TS_WIDTH     = TS_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int ALARM_THRESH = ALARM_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 clear,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic [CNT_WIDTH-1:0] evt_count,
  output logic                 overflow,
  output logic                 alarm
);

  logic [TS_WIDTH-1:0]  timestamp;
  logic                 trig_d;
  logic                 edge_det;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (!rst) timestamp <= '0;
    else      timestamp <= timestamp + 1'b1;
  end

  // trig_d comes out of reset high so a trigger already high is not an edge.
  // It keeps tracking during clear so the discarded edge is not seen again.
  always_ff @(posedge clk) begin
    if (!rst) trig_d <= 1'b1;
    else      trig_d <= trigger;
  end

  assign edge_det  = trigger & ~trig_d;
  assign push      = edge_det & ~clear;
  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;

  assign cnt_next = (evt_count == '1) ? evt_count : evt_count + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      evt_count <= '0;
      overflow  <= 1'b0;
      alarm     <= 1'b0;
    end else if (edge_det) begin
      evt_count <= cnt_next;
      if (cnt_next >= CNT_WIDTH'(ALARM_THRESH)) alarm <= 1'b1;
      if (fifo_full && !pop) overflow <= 1'b1;
    end
  end

  tsc_ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (timestamp),
    .pop   (pop),
    .clear (clear),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (evt_ts)
  );

endmodule

// File: tb/tb_tsc_trigger_monitor.sv
module tb_tsc_trigger_monitor;
  import tsc_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        clear;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_ts;
  logic [7:0]  evt_count;
  logic        overflow;
  logic        alarm;

  ts_t         ts_model = '0;
  ts_t         exp_q[$];

  int total = 0;
  int bad = 0;
  int sb_total = 0;
  int sb_bad = 0;

  tsc_trigger_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ts    (evt_ts),
    .evt_count (evt_count),
    .overflow  (overflow),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  // Reference free-running counter: zero while reset is sampled, +1 otherwise.
  always @(posedge clk) begin
    if (!rst) ts_model <= '0;
    else      ts_model <= ts_model + 16'd1;
  end

  // Scoreboard monitor: every accepted head is compared with the oldest
  // expected timestamp.
  always @(negedge clk) begin
    if (rst && !clear && evt_valid && evt_ready) begin
      sb_total++;
      if (exp_q.size() == 0) begin
        sb_bad++;
        $display("FAIL sb_unexpected: got ts=%h with no expected entry", evt_ts);
      end else begin
        ts_t e;
        e = exp_q.pop_front();
        if (evt_ts !== e) begin
          sb_bad++;
          $display("FAIL sb_ts: got %h want %h", evt_ts, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input ts_t target, input int budget);
    int n;
    n = 0;
    while (ts_model != target && n < budget) begin
      step();
      n++;
    end
    if (ts_model != target) begin
      total++;
      bad++;
      $display("FAIL wait_ts: got %h want %h", ts_model, target);
    end
  endtask

  // One-cycle high pulse on trigger; the edge is sampled with timestamp ts.
  task automatic pulse(input ts_t ts, input bit expect_q);
    trigger = 1'b1;
    if (expect_q) exp_q.push_back(ts);
    step();
    trigger = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    trigger = 1'b1;
    clear = 1'b0;
    evt_ready = 1'b0;

    // Reset held with trigger high, then released with trigger still high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", evt_valid, 0);
      chk("rst_count", evt_count, 0);
    end
    chk("rst_ovf", overflow, 0);
    chk("rst_alarm", alarm, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rel_valid", evt_valid, 0);
      chk("rel_count", evt_count, 0);
    end

    // Single event at timestamp 0x0010.
    evt_ready = 1'b1;
    wait_until(16'h000E, 100);
    trigger = 1'b0;
    wait_until(16'h0010, 100);
    pulse(16'h0010, 1'b1);
    chk("single_valid", evt_valid, 1);
    chk("single_ts", evt_ts, 32'h0010);
    chk("single_count", evt_count, 1);
    step();
    chk("single_drained", evt_valid, 0);

    // Start the overflow run from a zero count.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr0_count", evt_count, 0);

    // Overflow: five edges into a four-entry FIFO with the host stalled.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_until(16'h0100 + 16'(2*i), 1000);
      pulse(16'h0100 + 16'(2*i), i < 4);
      if (i == 1) chk("ovf_alarm_2", alarm, 0);
      if (i == 2) begin
        chk("ovf_alarm_3", alarm, 1);
        chk("ovf_count_3", evt_count, 3);
      end
      if (i == 3) chk("ovf_flag_4", overflow, 0);
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", evt_count, 5);
    chk("ovf_alarm", alarm, 1);
    chk("ovf_head", evt_ts, 32'h0100);

    // Clear with full FIFO, alarm, overflow and an edge in the same cycle.
    wait_until(16'h010A, 100);
    trigger = 1'b1;
    clear = 1'b1;
    step();
    trigger = 1'b0;
    clear = 1'b0;
    exp_q.delete();
    chk("clr_valid", evt_valid, 0);
    chk("clr_count", evt_count, 0);
    chk("clr_alarm", alarm, 0);
    chk("clr_ovf", overflow, 0);
    step();
    chk("clr_count_after", evt_count, 0);
    chk("clr_valid_after", evt_valid, 0);

    // Full FIFO with a push and a pop in the same cycle.
    for (int i = 0; i < 4; i++) begin
      wait_until(16'h0200 + 16'(2*i), 1000);
      pulse(16'h0200 + 16'(2*i), 1'b1);
    end
    wait_until(16'h0208, 100);
    evt_ready = 1'b1;
    trigger = 1'b1;
    exp_q.push_back(16'h0208);
    step();
    trigger = 1'b0;
    chk("fp_ovf", overflow, 0);
    chk("fp_valid", evt_valid, 1);
    chk("fp_head", evt_ts, 32'h0202);
    chk("fp_count", evt_count, 5);
    for (int i = 0; i < 6; i++) step();
    chk("fp_drained", evt_valid, 0);
    chk("fp_q_empty", exp_q.size(), 0);
    chk("fp_ovf_end", overflow, 0);

    // Timestamp wrap: edge on 0x0000.
    wait_until(16'h0000, 70000);
    pulse(16'h0000, 1'b1);
    chk("wrap_valid", evt_valid, 1);
    chk("wrap_ts", evt_ts, 32'h0000);
    chk("wrap_count", evt_count, 6);

    // Saturation: 300 more edges on top of a count of 6.
    wait_until(16'h0100, 1000);
    for (int i = 0; i < 300; i++) begin
      wait_until(16'h0100 + 16'(2*i), 100);
      pulse(16'h0100 + 16'(2*i), 1'b1);
      if (i == 247) chk("sat_count_254", evt_count, 254);
      if (i == 248) chk("sat_count_255", evt_count, 255);
    end
    chk("sat_count", evt_count, 255);
    chk("sat_alarm", alarm, 1);
    chk("sat_ovf", overflow, 0);
    step();
    step();
    chk("sat_q_empty", exp_q.size(), 0);

    // Reset mid-operation with queued events and the host ready.
    evt_ready = 1'b0;
    wait_until(16'h0400, 1000);
    pulse(16'h0400, 1'b1);
    wait_until(16'h0402, 100);
    pulse(16'h0402, 1'b1);
    chk("mid_valid_pre", evt_valid, 1);
    rst = 1'b0;
    evt_ready = 1'b1;
    step();
    rst = 1'b1;
    exp_q.delete();
    chk("mid_valid", evt_valid, 0);
    chk("mid_count", evt_count, 0);
    chk("mid_alarm", alarm, 0);
    step();
    chk("mid_valid_after", evt_valid, 0);

    step();
    total += sb_total;
    bad += sb_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
